// File: rtl/uart_tx_param.sv
// Parametrised async serial transmitter: start bit, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Parity stage is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tx_valid,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_tx_serial,
    output logic                 o_tx_active,
    output logic                 o_tx_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_param: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next state and next output values; the line value for each bit is set on the edge that starts it
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;
        ready_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                ready_d  = 1'b1;
                cnt_d    = '0;
                idx_d    = '0;
                if (i_tx_valid && ready_q) begin
                    state_d  = START;
                    shift_d  = i_tx_data;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                    ready_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^i_tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = DATA;
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        serial_d = parity_q;
`else
                        state_d  = STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = STOP;
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                serial_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        state_d  = DONE;
                        idx_d    = '0;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                active_d = 1'b0;
                ready_d  = 1'b1;
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    assign o_tx_ready  = ready_q;
    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboarded bench for uart_tx_param: queued expected words, line decoded cycle by cycle by a monitor.
// Adapts its frame model to UART_TX_PARITY_EN.
module tb_uart_tx_param;

    localparam int unsigned C  = 5;
    localparam int unsigned DW = 7;
    localparam int unsigned SB = 2;
    localparam int unsigned PO = 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned FB        = 1 + DW + PB + SB;
    localparam int unsigned FRAME_CYC = FB * C;
    localparam int          LIMIT     = 4000;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          b2b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready, serial, active, done;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   mon_busy = 1'b0;

    uart_tx_param #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (DW),
        .STOP_BITS   (SB),
        .PARITY_ODD  (PO)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_tx_valid (valid),
        .i_tx_data  (data),
        .o_tx_ready (ready),
        .o_tx_serial(serial),
        .o_tx_active(active),
        .o_tx_done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual time=%0t required below 2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1s
    function automatic logic exp_bit(input logic [DW-1:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= int'(DW)) return d[b-1];
        if (PB == 1 && b == int'(DW) + 1) return (^d) ^ 1'(PO);
        return 1'b1;
    endfunction

    // Monitor: decodes every frame on the line against the next queued word
    initial begin : monitor
        exp_t e;
        int   bad;
        int   last_stop = -100;
        forever begin
            @(negedge clk);
            if (mon_en && serial === 1'b0) begin
                mon_busy = 1'b1;
                if (q.size() == 0) begin
                    check_eq("unexpected_frame", 1, 0);
                    repeat (FRAME_CYC + 1) @(negedge clk);
                end else begin
                    e = q.pop_front();
                    if (e.b2b) check_eq("b2b_gap", cyc - last_stop - 1, 2);
                    for (int b = 0; b < int'(FB); b++) begin
                        bad = 0;
                        for (int c = 0; c < int'(C); c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (serial !== exp_bit(e.data, b) || active !== 1'b1 || ready !== 1'b0)
                                bad++;
                        end
                        if (bad != 0)
                            $display("  word=%0h bit=%0d expected line=%0b", e.data, b, exp_bit(e.data, b));
                        check_eq("frame_bit_bad_cycles", bad, 0);
                    end
                    last_stop = cyc;
                    @(negedge clk);
                    check_eq("done_cycle", {done, active, ready, serial}, 4'b1001);
                    @(negedge clk);
                    check_eq("done_single_pulse", done, 0);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) check_eq("ready_timeout", ready, 1);
    endtask

    task automatic send(input logic [DW-1:0] w, input bit pulse);
        wait_ready();
        valid = 1'b1;
        data  = w;
        q.push_back('{data: w, b2b: 1'b0});
        @(negedge clk);
        valid = 1'b0;
        data  = DW'($urandom);
        if (pulse) begin
            repeat ($urandom_range(1, FRAME_CYC - 2)) @(negedge clk);
            valid = 1'b1;
            data  = DW'($urandom);
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    task automatic send_pair(input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        wait_ready();
        valid = 1'b1;
        data  = w0;
        q.push_back('{data: w0, b2b: 1'b0});
        @(negedge clk);
        data = w1;
        q.push_back('{data: w1, b2b: 1'b1});
        wait_ready();
        @(negedge clk);
        valid = 1'b0;
        data  = DW'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || mon_busy || ready !== 1'b1) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", n < LIMIT, 1);
    endtask

    initial begin : stim
        int quiet;
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {serial, active, done, ready}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_reset", ready, 1);
        mon_en = 1'b1;

        send(7'h25, 1'b0);
        send(7'h55, 1'b0);
        send(7'h00, 1'b1);
        send(7'h7F, 1'b0);
        send_pair(7'h00, 7'h7F);

        // Mid-frame reset during data bit 3
        wait_idle();
        mon_en = 1'b0;
        valid  = 1'b1;
        data   = 7'h3C;
        @(negedge clk);
        valid = 1'b0;
        repeat (4 * C) @(negedge clk);
        check_eq("bit3_before_reset", serial, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_outputs", {serial, active, done, ready}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_abort", {ready, serial, active, done}, 4'b1100);
        quiet = 0;
        repeat (3 * C) begin
            @(negedge clk);
            if (done !== 1'b0 || serial !== 1'b1) quiet++;
        end
        check_eq("quiet_after_abort", quiet, 0);
        mon_en = 1'b1;
        send(7'h3C, 1'b0);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            case ($urandom_range(0, 2))
                0:       send(DW'($urandom), 1'b0);
                1:       send_pair(DW'($urandom), DW'($urandom));
                default: send(DW'($urandom), 1'b1);
            endcase
        end

        wait_idle();
        repeat (2 * FRAME_CYC) @(negedge clk);
        check_eq("queue_empty", q.size(), 0);
        check_eq("final_idle", {serial, active, done, ready}, 4'b1001);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
